// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the CPU IO bus. Stores to DATA_AD
//   are queued in a byte FIFO and shifted out LSB first on TX. A status word
//   is presented combinationally on RD_DATA when IOBUS_ADDR selects STAT_AD.
//
// Ports
//   CLK         system clock (same clock as the CPU bus)
//   RST         asynchronous, active-high reset
//   IOBUS_ADDR  CPU IO address
//   IOBUS_OUT   CPU store data; [7:0] is the TX byte, [3] is the OVF-clear bit
//   IOBUS_WR    store strobe, sampled on the rising edge of CLK
//   RD_DATA     status word at STAT_AD, else 0:
//               [0] FULL, [1] EMPTY, [2] BUSY, [3] OVF, [15:8] COUNT
//   TX          serial line, idle high, registered
//   BUSY        frame in progress or FIFO non-empty
//
// Handshake: there is no ready/backpressure toward the CPU. A push is accepted
// whenever a slot is free or a pop happens in the same cycle; otherwise the
// byte is dropped and the sticky OVF bit is raised until software clears it.
module mmio_uart_tx #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] DATA_AD    = 32'h11000060,
  parameter logic [31:0] STAT_AD    = 32'h11000064
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX,
  output logic        BUSY
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic push_req;
  logic ctrl_wr;
  logic ovf_clr;
  logic unused_data_hi;

  assign push_req       = IOBUS_WR && (IOBUS_ADDR == DATA_AD);
  assign ctrl_wr        = IOBUS_WR && (IOBUS_ADDR == STAT_AD);
  assign ovf_clr        = ctrl_wr && IOBUS_OUT[3];
  assign unused_data_hi = ^IOBUS_OUT[31:8];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;
  logic [7:0]    head;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  // A full FIFO still accepts a byte when the transmitter pops in the same
  // cycle, so a streaming writer never loses data at the boundary.
  assign push_ok = push_req && (!fifo_full || pop);
  assign ovf_set = push_req && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= IOBUS_OUT[7:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push_ok) begin
        count <= count - CW'(1);
      end
      // Overflow in the same cycle as a clear keeps the flag set.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic          tx_nxt;
  logic          baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      TX       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      TX       <= tx_nxt;
    end
  end

  // TX is registered from the next-state line level, so the line changes on
  // the same edge as the state and a pop at edge k drives the start bit
  // immediately after k.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = 1'b1;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          state_nxt = S_START;
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (baud_done) begin
          state_nxt = S_DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shift[0];
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      S_DATA: begin
        tx_nxt = shift[0];
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      S_STOP: begin
        tx_nxt = 1'b1;
        if (baud_done) begin
          baud_nxt = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            state_nxt = S_START;
            bit_nxt   = '0;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign BUSY = (state != S_IDLE) || !fifo_empty;

  // ---------------------------------------------------------------------------
  // Status read
  // ---------------------------------------------------------------------------
  always_comb begin
    RD_DATA = '0;
    if (IOBUS_ADDR == STAT_AD) begin
      RD_DATA[0]    = fifo_full;
      RD_DATA[1]    = fifo_empty;
      RD_DATA[2]    = BUSY;
      RD_DATA[3]    = ovf;
      RD_DATA[15:8] = 8'(count);
    end
  end

endmodule
